// File: rtl/tx_initiated_point_test_tx.sv
// TX-side controller for the TX-initiated D2C point test.
// Sequences TEST_REQ, LFSR_CLEAR_REQ, a fixed pattern window, RESULT_REQ and END_REQ
// over the shared sideband, captures the partner's results and raises a finish ack.
module tx_initiated_point_test_tx #(
  parameter int unsigned PATTERN_CYCLES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_mainband_or_valtrain_test,
  input  logic        i_lfsr_or_perlane,
  input  logic        i_valid_rx,
  input  logic        i_busy_negedge_detected,
  input  logic [3:0]  i_sideband_message,
  input  logic        i_sideband_message_valid,
  input  logic [15:0] i_sideband_data,
  input  logic        i_msg_info,
  output logic [3:0]  o_sideband_message,
  output logic [15:0] o_sideband_data,
  output logic        o_valid_tx,
  output logic        o_data_valid,
  output logic [1:0]  o_mainband_pattern_generator_cw,
  output logic        o_valtrain_en,
  output logic [15:0] o_results,
  output logic        o_result_info,
  output logic        o_test_ack_tx
);

  localparam int unsigned CntW = $clog2(PATTERN_CYCLES + 1);

  localparam logic [3:0] StIdle              = 4'd0;
  localparam logic [3:0] StSendTestReq       = 4'd1;
  localparam logic [3:0] StWaitTestResp      = 4'd2;
  localparam logic [3:0] StSendLfsrClearReq  = 4'd3;
  localparam logic [3:0] StWaitLfsrClearResp = 4'd4;
  localparam logic [3:0] StSendPattern       = 4'd5;
  localparam logic [3:0] StSendResultReq     = 4'd6;
  localparam logic [3:0] StWaitResultResp    = 4'd7;
  localparam logic [3:0] StSendEndReq        = 4'd8;
  localparam logic [3:0] StWaitEndResp       = 4'd9;
  localparam logic [3:0] StTestFinish        = 4'd10;

  localparam logic [3:0] MsgTestReq       = 4'b0001;
  localparam logic [3:0] MsgTestResp      = 4'b0010;
  localparam logic [3:0] MsgLfsrClearReq  = 4'b0011;
  localparam logic [3:0] MsgLfsrClearResp = 4'b0100;
  localparam logic [3:0] MsgResultReq     = 4'b0101;
  localparam logic [3:0] MsgResultResp    = 4'b0110;
  localparam logic [3:0] MsgEndReq        = 4'b0111;
  localparam logic [3:0] MsgEndResp       = 4'b1000;

  logic [3:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic            pending_q;
  logic            valid_d_q;
  logic            valid_negedge;
  logic            enter_send;
  logic [3:0]      send_msg;

  // A SEND_* state is done once our request has been served and valid has dropped.
  assign valid_negedge = valid_d_q & ~o_valid_tx;

  // Next-state decode; i_en low overrides everything and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:              if (i_en) state_d = StSendTestReq;
      StSendTestReq:       if (valid_negedge) state_d = StWaitTestResp;
      StWaitTestResp:      if (i_sideband_message_valid && i_sideband_message == MsgTestResp)
                             state_d = StSendLfsrClearReq;
      StSendLfsrClearReq:  if (valid_negedge) state_d = StWaitLfsrClearResp;
      StWaitLfsrClearResp: if (i_sideband_message_valid && i_sideband_message == MsgLfsrClearResp)
                             state_d = StSendPattern;
      StSendPattern:       if (cnt_q == CntW'(PATTERN_CYCLES - 1)) state_d = StSendResultReq;
      StSendResultReq:     if (valid_negedge) state_d = StWaitResultResp;
      StWaitResultResp:    if (i_sideband_message_valid && i_sideband_message == MsgResultResp)
                             state_d = StSendEndReq;
      StSendEndReq:        if (valid_negedge) state_d = StWaitEndResp;
      StWaitEndResp:       if (i_sideband_message_valid && i_sideband_message == MsgEndResp)
                             state_d = StTestFinish;
      StTestFinish:        state_d = StTestFinish;
      default:             state_d = StIdle;
    endcase
    if (!i_en) state_d = StIdle;
  end

  // Detect entry into a request state and pick the message it sends.
  always_comb begin
    enter_send = (state_d != state_q);
    send_msg   = 4'b0000;
    case (state_d)
      StSendTestReq:      send_msg = MsgTestReq;
      StSendLfsrClearReq: send_msg = MsgLfsrClearReq;
      StSendResultReq:    send_msg = MsgResultReq;
      StSendEndReq:       send_msg = MsgEndReq;
      default:            enter_send = 1'b0;
    endcase
  end

  // State, sideband handshake, pattern window and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                         <= StIdle;
      cnt_q                           <= '0;
      pending_q                       <= 1'b0;
      valid_d_q                       <= 1'b0;
      o_sideband_message              <= 4'b0000;
      o_sideband_data                 <= 16'h0000;
      o_valid_tx                      <= 1'b0;
      o_data_valid                    <= 1'b0;
      o_mainband_pattern_generator_cw <= 2'b00;
      o_valtrain_en                   <= 1'b0;
      o_results                       <= 16'h0000;
      o_result_info                   <= 1'b0;
      o_test_ack_tx                   <= 1'b0;
    end else if (state_d == StIdle) begin
      // Abort or idle: everything but the captured results goes quiet.
      state_q                         <= StIdle;
      cnt_q                           <= '0;
      pending_q                       <= 1'b0;
      valid_d_q                       <= 1'b0;
      o_sideband_message              <= 4'b0000;
      o_sideband_data                 <= 16'h0000;
      o_valid_tx                      <= 1'b0;
      o_data_valid                    <= 1'b0;
      o_mainband_pattern_generator_cw <= 2'b00;
      o_valtrain_en                   <= 1'b0;
      o_test_ack_tx                   <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_d_q <= o_valid_tx;

      // A busy pulse may belong to an RX transfer, so it never touches pending, and data
      // validity is only dropped when it is our own transfer that finished.
      if (i_busy_negedge_detected) begin
        o_valid_tx <= 1'b0;
        if (o_valid_tx) o_data_valid <= 1'b0;
      end
      if (pending_q && !i_valid_rx) begin
        o_valid_tx <= 1'b1;
        pending_q  <= 1'b0;
      end

      if (enter_send) begin
        o_sideband_message <= send_msg;
        o_valid_tx         <= ~i_valid_rx;
        pending_q          <= i_valid_rx;
        if (send_msg == MsgTestReq) begin
          o_sideband_data <= {14'b0, i_lfsr_or_perlane, i_mainband_or_valtrain_test};
          o_data_valid    <= 1'b1;
          o_results       <= 16'h0000;
          o_result_info   <= 1'b0;
        end else begin
          o_sideband_data <= 16'h0000;
          o_data_valid    <= 1'b0;
        end
      end

      // Pattern window: first mainband cycle clears the LFSR, the rest run the pattern.
      if (state_d == StSendPattern) begin
        o_valtrain_en <= i_mainband_or_valtrain_test;
        if (state_q != StSendPattern) begin
          cnt_q                           <= '0;
          o_mainband_pattern_generator_cw <= i_mainband_or_valtrain_test ? 2'b00 : 2'b01;
        end else begin
          cnt_q                           <= cnt_q + CntW'(1);
          o_mainband_pattern_generator_cw <= i_mainband_or_valtrain_test ? 2'b00 :
                                             {1'b1, i_lfsr_or_perlane};
        end
      end else begin
        o_mainband_pattern_generator_cw <= 2'b00;
        o_valtrain_en                   <= 1'b0;
      end

      if (state_q == StWaitResultResp && state_d == StSendEndReq) begin
        o_results     <= i_sideband_data;
        o_result_info <= i_msg_info;
      end

      o_test_ack_tx <= (state_d == StTestFinish);
    end
  end

endmodule

// File: tb/tb_tx_initiated_point_test_tx.sv
// Directed bench for tx_initiated_point_test_tx: the stimulus schedule derives the
// expected outputs from the protocol rules, a negedge process compares them every cycle.
module tb_tx_initiated_point_test_tx;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_mainband_or_valtrain_test = 1'b0;
  logic        i_lfsr_or_perlane = 1'b0;
  logic        i_valid_rx = 1'b0;
  logic        i_busy_negedge_detected = 1'b0;
  logic [3:0]  i_sideband_message = 4'b0000;
  logic        i_sideband_message_valid = 1'b0;
  logic [15:0] i_sideband_data = 16'h0000;
  logic        i_msg_info = 1'b0;
  logic [3:0]  o_sideband_message;
  logic [15:0] o_sideband_data;
  logic        o_valid_tx;
  logic        o_data_valid;
  logic [1:0]  o_mainband_pattern_generator_cw;
  logic        o_valtrain_en;
  logic [15:0] o_results;
  logic        o_result_info;
  logic        o_test_ack_tx;

  tx_initiated_point_test_tx #(.PATTERN_CYCLES(P)) dut (
    .clk                             (clk),
    .rst                             (rst),
    .i_en                            (i_en),
    .i_mainband_or_valtrain_test     (i_mainband_or_valtrain_test),
    .i_lfsr_or_perlane               (i_lfsr_or_perlane),
    .i_valid_rx                      (i_valid_rx),
    .i_busy_negedge_detected         (i_busy_negedge_detected),
    .i_sideband_message              (i_sideband_message),
    .i_sideband_message_valid        (i_sideband_message_valid),
    .i_sideband_data                 (i_sideband_data),
    .i_msg_info                      (i_msg_info),
    .o_sideband_message              (o_sideband_message),
    .o_sideband_data                 (o_sideband_data),
    .o_valid_tx                      (o_valid_tx),
    .o_data_valid                    (o_data_valid),
    .o_mainband_pattern_generator_cw (o_mainband_pattern_generator_cw),
    .o_valtrain_en                   (o_valtrain_en),
    .o_results                       (o_results),
    .o_result_info                   (o_result_info),
    .o_test_ack_tx                   (o_test_ack_tx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Expected outputs, updated by the stimulus right after each active edge.
  logic [3:0]  exp_msg;
  logic [15:0] exp_data;
  logic        exp_valid, exp_dv, exp_vt, exp_info, exp_ack;
  logic [1:0]  exp_cw;
  logic [15:0] exp_res;

  logic [1:0]  cw_log [P+1];
  logic [15:0] treq_data;
  int          vt_cnt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the expectation model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("msg",     {12'b0, o_sideband_message}, {12'b0, exp_msg});
      check("data",    o_sideband_data, exp_data);
      check("valid",   {15'b0, o_valid_tx}, {15'b0, exp_valid});
      check("dvalid",  {15'b0, o_data_valid}, {15'b0, exp_dv});
      check("cw",      {14'b0, o_mainband_pattern_generator_cw}, {14'b0, exp_cw});
      check("valtr",   {15'b0, o_valtrain_en}, {15'b0, exp_vt});
      check("results", o_results, exp_res);
      check("info",    {15'b0, o_result_info}, {15'b0, exp_info});
      check("ack",     {15'b0, o_test_ack_tx}, {15'b0, exp_ack});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_quiet();
    exp_msg = 4'b0000; exp_data = 16'h0000; exp_valid = 1'b0; exp_dv = 1'b0;
    exp_cw = 2'b00; exp_vt = 1'b0; exp_ack = 1'b0;
  endtask

  // Enable from IDLE: TEST_REQ goes out one edge later and the results are cleared.
  task automatic start(input logic mb, input logic lp);
    i_mainband_or_valtrain_test = mb;
    i_lfsr_or_perlane = lp;
    i_en = 1'b1;
    tick();
    exp_msg = 4'b0001; exp_data = {14'b0, lp, mb}; exp_dv = 1'b1; exp_valid = 1'b1;
    exp_res = 16'h0000; exp_info = 1'b0;
    treq_data = o_sideband_data;
  endtask

  // Serializer model: busy pulse 3 cycles after valid; state exits one cycle after valid falls.
  task automatic serialize();
    tick();
    tick();
    i_busy_negedge_detected = 1'b1;
    tick();
    i_busy_negedge_detected = 1'b0;
    exp_valid = 1'b0; exp_dv = 1'b0;
    tick();
  endtask

  // Partner response after one idle cycle in the WAIT state.
  task automatic respond(input logic [3:0] msg, input logic [15:0] data, input logic info);
    tick();
    i_sideband_message = msg; i_sideband_message_valid = 1'b1;
    i_sideband_data = data; i_msg_info = info;
    tick();
    i_sideband_message = 4'b0000; i_sideband_message_valid = 1'b0;
    i_sideband_data = 16'h0000; i_msg_info = 1'b0;
  endtask

  task automatic to_pattern(input logic mb, input logic lp, input bit wrong);
    start(mb, lp);
    serialize();
    if (wrong) begin
      i_sideband_message = 4'b0110; i_sideband_message_valid = 1'b1;
      tick();
      i_sideband_message = 4'b0010; i_sideband_message_valid = 1'b0;
      tick();
      i_sideband_message = 4'b0000;
    end
    respond(4'b0010, 16'h0000, 1'b0);
    exp_msg = 4'b0011; exp_data = 16'h0000; exp_dv = 1'b0; exp_valid = 1'b1;
    serialize();
    respond(4'b0100, 16'h0000, 1'b0);
    exp_cw = mb ? 2'b00 : 2'b01; exp_vt = mb;
    cw_log[0] = o_mainband_pattern_generator_cw;
    vt_cnt = int'(o_valtrain_en);
  endtask

  // Rest of the window, then RESULT_REQ (optionally blocked by RX) and END_REQ.
  task automatic result_phase(input logic mb, input logic lp, input bit rx_hold,
                              input logic [15:0] rdata, input logic rinfo);
    for (int k = 1; k < P; k++) begin
      tick();
      exp_cw = mb ? 2'b00 : {1'b1, lp};
      cw_log[k] = o_mainband_pattern_generator_cw;
      vt_cnt += int'(o_valtrain_en);
    end
    if (rx_hold) i_valid_rx = 1'b1;
    tick();
    exp_cw = 2'b00; exp_vt = 1'b0;
    exp_msg = 4'b0101; exp_data = 16'h0000; exp_dv = 1'b0; exp_valid = !rx_hold;
    cw_log[P] = o_mainband_pattern_generator_cw;
    vt_cnt += int'(o_valtrain_en);
    if (rx_hold) begin
      tick();
      tick();
      i_busy_negedge_detected = 1'b1;
      tick();
      i_busy_negedge_detected = 1'b0;
      tick();
      tick();
      i_valid_rx = 1'b0;
      tick();
      exp_valid = 1'b1;
    end
    serialize();
    respond(4'b0110, rdata, rinfo);
    exp_res = rdata; exp_info = rinfo;
    exp_msg = 4'b0111; exp_valid = 1'b1;
    serialize();
  endtask

  task automatic end_phase();
    respond(4'b1000, 16'h0000, 1'b0);
    exp_ack = 1'b1;
    tick();
    tick();
    i_en = 1'b0;
    tick();
    exp_quiet();
  endtask

  initial begin
    logic [1:0] lit_lfsr [P+1];
    logic [1:0] lit_lane [P+1];
    lit_lfsr[0] = 2'b01; lit_lfsr[1] = 2'b10; lit_lfsr[2] = 2'b10; lit_lfsr[3] = 2'b10;
    lit_lfsr[4] = 2'b00;
    lit_lane[0] = 2'b01; lit_lane[1] = 2'b11; lit_lane[2] = 2'b11; lit_lane[3] = 2'b11;
    lit_lane[4] = 2'b00;

    // Reset state.
    tick();
    exp_quiet(); exp_res = 16'h0000; exp_info = 1'b0;
    chk_on = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Mainband LFSR run, with stray messages while waiting for TEST_RESP.
    to_pattern(1'b0, 1'b0, 1'b1);
    result_phase(1'b0, 1'b0, 1'b0, 16'hA5A5, 1'b1);
    end_phase();
    check("lfsr_treq_data", treq_data, 16'h0000);
    for (int k = 0; k <= P; k++) check("lfsr_cw_seq", {14'b0, cw_log[k]}, {14'b0, lit_lfsr[k]});
    check("lfsr_results", o_results, 16'hA5A5);
    check("lfsr_info", {15'b0, o_result_info}, 16'h0001);
    tick();

    // Abort with a request on the wire, then abort mid pattern window.
    start(1'b0, 1'b1);
    tick();
    i_en = 1'b0;
    tick();
    exp_quiet();
    tick();
    to_pattern(1'b0, 1'b1, 1'b0);
    tick();
    exp_cw = 2'b11;
    i_en = 1'b0;
    tick();
    exp_quiet();
    tick();

    // Per-lane run with RX holding the sideband on RESULT_REQ entry.
    to_pattern(1'b0, 1'b1, 1'b0);
    result_phase(1'b0, 1'b1, 1'b1, 16'h3C0F, 1'b0);
    end_phase();
    check("lane_treq_data", treq_data, 16'h0002);
    for (int k = 0; k <= P; k++) check("lane_cw_seq", {14'b0, cw_log[k]}, {14'b0, lit_lane[k]});
    check("lane_results", o_results, 16'h3C0F);
    tick();

    // Valtrain run.
    to_pattern(1'b1, 1'b0, 1'b0);
    result_phase(1'b1, 1'b0, 1'b0, 16'h0F0F, 1'b1);
    end_phase();
    check("vt_treq_data", treq_data, 16'h0001);
    check("vt_cycles", 16'(vt_cnt), 16'd4);
    check("vt_results", o_results, 16'h0F0F);
    tick();

    // Reset while waiting for END_RESP, with the awaited response arriving on the same edge.
    to_pattern(1'b0, 1'b0, 1'b0);
    result_phase(1'b0, 1'b0, 1'b0, 16'h1234, 1'b1);
    tick();
    rst = 1'b1;
    i_sideband_message = 4'b1000; i_sideband_message_valid = 1'b1;
    tick();
    exp_quiet(); exp_res = 16'h0000; exp_info = 1'b0;
    rst = 1'b0;
    i_sideband_message = 4'b0000; i_sideband_message_valid = 1'b0;
    check("rst_results", o_results, 16'h0000);
    start(1'b0, 1'b0);
    check("rst_restart_msg", {12'b0, o_sideband_message}, 16'h0001);
    i_en = 1'b0;
    tick();
    exp_quiet();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
